// File: rtl/conv_pkg.sv
// Shared pixel and window types for the 3x3 convolution pipeline.
package conv_pkg;

   localparam int unsigned PIXEL_W     = 16;
   localparam int unsigned R_MSB       = 15;
   localparam int unsigned R_LSB       = 11;
   localparam int unsigned G_MSB       = 10;
   localparam int unsigned G_LSB       = 5;
   localparam int unsigned B_MSB       = 4;
   localparam int unsigned B_LSB       = 0;
   localparam int unsigned KERNEL_TAPS = 9;

   typedef logic [PIXEL_W-1:0] pixel_t;

   // Index 3*r+c; r=0 is the oldest line, c=0 the leftmost column.
   typedef pixel_t [KERNEL_TAPS-1:0] window_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line buffer: synchronous read-before-write, one-cycle read latency.
module line_ram #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_en,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // No reset on the array or read register so the tools map it to block RAM.
   always_ff @(posedge clk) begin
      if (i_en) begin
         o_rdata <= r_mem[i_addr];
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Builds 3x3 neighbourhoods from a raster RGB565 stream using two line buffers.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  pixel_valid,
   input  logic [PIXEL_W-1:0]                    pixel_in,
   input  logic                                  sof,
   output logic                                  valid_buffer,
   output logic [KERNEL_TAPS-1:0][PIXEL_W-1:0]   pixel_buffer,
   output logic                                  frame_done
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [CW-1:0] w_cur_col;
   logic [RW-1:0] w_cur_row;
   logic [CW-1:0] w_nxt_col;
   logic [RW-1:0] w_nxt_row;
   logic          w_win_ok;
   logic          w_last;

   logic          r_s1_acc;
   pixel_t        r_s1_pix;
   logic [CW-1:0] r_s1_col;
   logic          r_s1_win;
   logic          r_s1_last;

   logic          r_s2_acc;
   pixel_t        r_s2_pix;
   pixel_t        r_s2_l1;
   logic          r_s2_win;
   logic          r_s2_last;

   pixel_t        w_l1_rdata;
   pixel_t        w_l2_rdata;
   window_t       r_win;
   window_t       w_win_next;

   // Coordinates of the pixel on the bus this cycle and where the counters go next.
   always_comb begin
      w_cur_col = r_col;
      w_cur_row = r_row;
      if (sof) begin
         w_cur_col = '0;
         w_cur_row = '0;
      end
      w_nxt_col = w_cur_col + CW'(1);
      w_nxt_row = w_cur_row;
      if (w_cur_col == COL_LAST) begin
         w_nxt_col = '0;
         w_nxt_row = (w_cur_row == ROW_LAST) ? '0 : w_cur_row + RW'(1);
      end
   end

   assign w_win_ok = (w_cur_row >= RW'(2)) && (w_cur_col >= CW'(2));
   assign w_last   = (w_cur_row == ROW_LAST) && (w_cur_col == COL_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (pixel_valid) begin
         r_col <= w_nxt_col;
         r_row <= w_nxt_row;
      end
   end

   // L1 is accessed on acceptance; L2 one cycle later so its write data is L1's old word.
   line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W), .AW(CW)) u_l1 (
      .clk     (clk),
      .i_en    (pixel_valid),
      .i_we    (pixel_valid),
      .i_addr  (w_cur_col),
      .i_wdata (pixel_in),
      .o_rdata (w_l1_rdata)
   );

   line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W), .AW(CW)) u_l2 (
      .clk     (clk),
      .i_en    (r_s1_acc),
      .i_we    (r_s1_acc),
      .i_addr  (r_s1_col),
      .i_wdata (w_l1_rdata),
      .o_rdata (w_l2_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_acc  <= 1'b0;
         r_s1_pix  <= '0;
         r_s1_col  <= '0;
         r_s1_win  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s2_acc  <= 1'b0;
         r_s2_pix  <= '0;
         r_s2_l1   <= '0;
         r_s2_win  <= 1'b0;
         r_s2_last <= 1'b0;
      end else begin
         r_s1_acc  <= pixel_valid;
         r_s1_win  <= pixel_valid & w_win_ok;
         r_s1_last <= pixel_valid & w_last;
         if (pixel_valid) begin
            r_s1_pix <= pixel_in;
            r_s1_col <= w_cur_col;
         end
         r_s2_acc  <= r_s1_acc;
         r_s2_win  <= r_s1_acc & r_s1_win;
         r_s2_last <= r_s1_acc & r_s1_last;
         if (r_s1_acc) begin
            r_s2_pix <= r_s1_pix;
            r_s2_l1  <= w_l1_rdata;
         end
      end
   end

   // Shift left; new right column is {line r-2, line r-1, current line}.
   assign w_win_next = {r_s2_pix,   r_win[8], r_win[7],
                        r_s2_l1,    r_win[5], r_win[4],
                        w_l2_rdata, r_win[2], r_win[1]};

   // The output copy only loads on full windows so it holds between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_win        <= '0;
         pixel_buffer <= '0;
         valid_buffer <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         valid_buffer <= r_s2_acc & r_s2_win;
         frame_done   <= r_s2_acc & r_s2_win & r_s2_last;
         if (r_s2_acc) begin
            r_win <= w_win_next;
         end
         if (r_s2_acc && r_s2_win) begin
            pixel_buffer <= w_win_next;
         end
      end
   end

endmodule
